// File: rtl/operand_stack.sv
// rtl/operand_stack.sv - parametrised LIFO operand stack with sticky misuse flag
//
// Holds up to DEPTH operands of BITS width. Supports push, pop, replace-top
// (push+pop), swap and clear. The top two entries are exposed continuously.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   d      in   operand to push or write into the top entry
//   push   in   push d
//   pop    in   discard top entry
//   swap   in   exchange top and next entries
//   clear  in   empty the stack and clear err
//   top    out  top entry, 0 when count == 0
//   next   out  second entry, 0 when count < 2
//   count  out  number of valid entries
//   empty  out  count == 0
//   full   out  count == DEPTH
//   err    out  sticky error flag (overflow, underflow, bad swap, bad combo)
module operand_stack #(
    parameter int  BITS  = 8,
    parameter int  DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BITS-1:0]  d,
    input  logic             push,
    input  logic             pop,
    input  logic             swap,
    input  logic             clear,
    output logic [BITS-1:0]  top,
    output logic [BITS-1:0]  next,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BITS-1:0]  mem_q [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Storage write controls, computed combinationally and applied in the
    // storage process so the array itself carries no reset.
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic             sw_en;

    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] nxt_idx;
    logic             has_one;
    logic             has_two;
    logic             is_full;

    assign top_idx = IDX_W'(cnt_q - CNT_W'(1));
    assign nxt_idx = IDX_W'(cnt_q - CNT_W'(2));
    assign has_one = (cnt_q != '0);
    assign has_two = (cnt_q > CNT_W'(1));
    assign is_full = (cnt_q == CNT_W'(DEPTH));

    always_comb begin
        cnt_d  = cnt_q;
        err_d  = err_q;
        wr_en  = 1'b0;
        wr_idx = top_idx;
        sw_en  = 1'b0;
        if (reset || clear) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else begin
            unique case ({push, pop, swap})
                3'b000: ;
                3'b100: begin
                    if (is_full) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en  = 1'b1;
                        wr_idx = IDX_W'(cnt_q);
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
                3'b010: begin
                    if (has_one) cnt_d = cnt_q - CNT_W'(1);
                    else         err_d = 1'b1;
                end
                3'b110: begin
                    // Replace-top; on an empty stack it degrades to a plain push.
                    wr_en = 1'b1;
                    if (!has_one) begin
                        wr_idx = '0;
                        cnt_d  = CNT_W'(1);
                    end
                end
                3'b001: begin
                    if (has_two) sw_en = 1'b1;
                    else         err_d = 1'b1;
                end
                default: err_d = 1'b1;  // swap combined with push and/or pop
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= d;
        end
        if (sw_en) begin
            mem_q[top_idx] <= mem_q[nxt_idx];
            mem_q[nxt_idx] <= mem_q[top_idx];
        end
    end

    assign top   = has_one ? mem_q[top_idx] : '0;
    assign next  = has_two ? mem_q[nxt_idx] : '0;
    assign count = cnt_q;
    assign empty = !has_one;
    assign full  = is_full;
    assign err   = err_q;
endmodule

// File: tb/tb_operand_stack.sv
// tb/tb_operand_stack.sv - self-checking bench for operand_stack
module tb_operand_stack;
    localparam int BITS  = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [BITS-1:0]  d = '0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             swap = 1'b0;
    logic             clear = 1'b0;
    logic [BITS-1:0]  top;
    logic [BITS-1:0]  next;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             err;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    logic [BITS-1:0] stk[$];
    bit              merr = 1'b0;

    operand_stack #(.BITS(BITS), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .push  (push),
        .pop   (pop),
        .swap  (swap),
        .clear (clear),
        .top   (top),
        .next  (next),
        .count (count),
        .empty (empty),
        .full  (full),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stack semantics applied to a queue; the last element is the top.
    task automatic model_apply();
        int n;
        logic [BITS-1:0] t;
        n = stk.size();
        if (reset || clear) begin
            stk.delete();
            merr = 1'b0;
        end else begin
            case ({push, pop, swap})
                3'b000: ;
                3'b100: if (n < DEPTH) stk.push_back(d); else merr = 1'b1;
                3'b010: if (n > 0) void'(stk.pop_back()); else merr = 1'b1;
                3'b110: if (n > 0) stk[n-1] = d; else stk.push_back(d);
                3'b001: begin
                    if (n >= 2) begin
                        t = stk[n-1];
                        stk[n-1] = stk[n-2];
                        stk[n-2] = t;
                    end else begin
                        merr = 1'b1;
                    end
                end
                default: merr = 1'b1;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            int n;
            n = stk.size();
            chk("m_count", 32'(count), 32'(n));
            chk("m_top",   32'(top),   (n > 0) ? 32'(stk[n-1]) : 32'd0);
            chk("m_next",  32'(next),  (n > 1) ? 32'(stk[n-2]) : 32'd0);
            chk("m_empty", 32'(empty), 32'(n == 0));
            chk("m_full",  32'(full),  32'(n == DEPTH));
            chk("m_err",   32'(err),   32'(merr));
        end
    end

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit r, input bit c, input bit pu, input bit po,
                        input bit sw, input logic [BITS-1:0] dv);
        reset = r; clear = c; push = pu; pop = po; swap = sw; d = dv;
        @(posedge clk);
        model_apply();
        @(negedge clk);
        reset = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; swap = 1'b0;
    endtask

    task automatic lit(input string name, input logic [BITS-1:0] t, input logic [BITS-1:0] nx,
                       input int c, input bit e);
        chk({name, "_top"},   32'(top),   32'(t));
        chk({name, "_next"},  32'(next),  32'(nx));
        chk({name, "_count"}, 32'(count), 32'(c));
        chk({name, "_err"},   32'(err),   32'(e));
    endtask

    initial begin
        @(negedge clk);
        // Reset held 2 cycles with a push pending: push must be discarded.
        step(1, 0, 1, 0, 0, 8'h5A);
        check_en = 1'b1;
        step(1, 0, 1, 0, 0, 8'h5A);
        lit("reset", 8'h00, 8'h00, 0, 0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full",  32'(full),  32'd0);

        // Fill and overflow
        step(0, 0, 1, 0, 0, 8'h11);
        step(0, 0, 1, 0, 0, 8'h22);
        step(0, 0, 1, 0, 0, 8'h33);
        step(0, 0, 1, 0, 0, 8'h44);
        lit("fill", 8'h44, 8'h33, 4, 0);
        chk("fill_full", 32'(full), 32'd1);
        step(0, 0, 1, 0, 0, 8'h55);
        lit("ovf", 8'h44, 8'h33, 4, 1);
        step(0, 0, 1, 1, 0, 8'h66);
        lit("repl_full", 8'h66, 8'h33, 4, 1);

        // Clear and underflow
        step(0, 1, 0, 0, 0, 8'h00);
        lit("clear", 8'h00, 8'h00, 0, 0);
        chk("clear_empty", 32'(empty), 32'd1);
        step(0, 0, 0, 1, 0, 8'h00);
        lit("udf", 8'h00, 8'h00, 0, 1);
        step(0, 0, 1, 1, 0, 8'h77);
        lit("repl_empty", 8'h77, 8'h00, 1, 1);

        // Swap
        step(0, 1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 0, 0, 8'hA1);
        step(0, 0, 1, 0, 0, 8'hB2);
        step(0, 0, 0, 0, 1, 8'h00);
        lit("swap", 8'hA1, 8'hB2, 2, 0);
        step(0, 0, 0, 1, 0, 8'h00);
        lit("swap_pop", 8'hB2, 8'h00, 1, 0);
        step(0, 0, 0, 0, 1, 8'h00);
        lit("swap_short", 8'hB2, 8'h00, 1, 1);

        // Illegal combinations leave storage and count untouched
        step(0, 1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 0, 0, 8'h01);
        step(0, 0, 1, 0, 0, 8'h02);
        step(0, 0, 0, 1, 1, 8'h00);
        lit("swap_pop_ill", 8'h02, 8'h01, 2, 1);
        step(0, 0, 1, 0, 1, 8'hEE);
        lit("swap_push_ill", 8'h02, 8'h01, 2, 1);
        step(0, 0, 1, 1, 1, 8'hEE);

        // Back-to-back, then clear beating push
        step(0, 1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 0, 0, 8'h01);
        step(0, 0, 1, 0, 0, 8'h02);
        step(0, 0, 0, 1, 0, 8'h00);
        step(0, 0, 1, 0, 0, 8'h03);
        lit("b2b", 8'h03, 8'h01, 2, 0);
        step(0, 1, 1, 0, 0, 8'h09);
        lit("clear_push", 8'h00, 8'h00, 0, 0);

        // Held push re-executes each cycle up to overflow, then mid-sequence
        // reset and a command on the very first cycle after it.
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0, 8'(8'hC0 + i));
        lit("held_push", 8'hC3, 8'hC2, 4, 1);
        step(1, 0, 0, 1, 0, 8'h00);
        lit("mid_reset", 8'h00, 8'h00, 0, 0);
        step(0, 0, 1, 0, 0, 8'h3C);
        lit("post_reset", 8'h3C, 8'h00, 1, 0);
        step(0, 0, 0, 0, 0, 8'h00);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
